// File: rtl/mac_seq_pkg.sv
// ============================================================================
//  Module   : mac_seq_pkg
//  Purpose  : Shared types and constants for the MAC sequencer: FSM state
//             enum, FP32 zero constant and drain-counter width helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_seq_pkg;

    // Sequencer states, in the order a normal job visits them
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        CLRW  = 3'd2,
        FEED  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    localparam int DEF_RD_LAT    = 1;
    localparam int DEF_DRAIN_CYC = 4;

    // The drain counter runs 0 .. cycles-1, so it needs clog2(cycles) bits (min 1)
    function automatic int drain_cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

    localparam int DRAIN_CW = drain_cnt_w(DEF_RD_LAT + DEF_DRAIN_CYC);

endpackage

`default_nettype wire

// File: rtl/mac_seq_addr_gen.sv
// ============================================================================
//  Module   : mac_seq_addr_gen
//  Purpose  : Operand address generator shared by SRAM ports A and B.
//             Two wrapping word-address counters plus an element counter
//             that flags the last element and an empty (len==0) job.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_seq_addr_gen #(
    parameter int AW = 12,
    parameter int LW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          advance,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    input  logic [LW-1:0] len,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          last,
    output logic          empty
);

    logic [LW-1:0] remaining;

    // Load bases/length on job accept; step both addresses per issued read pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_addr    <= '0;
            b_addr    <= '0;
            remaining <= '0;
        end else if (load) begin
            a_addr    <= base_a;
            b_addr    <= base_b;
            remaining <= len;
        end else if (advance) begin
            // Natural overflow gives the mod 2^AW wrap
            a_addr    <= a_addr + 1'b1;
            b_addr    <= b_addr + 1'b1;
            if (remaining != '0) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

    // Flags derived from the remaining-element count
    always_comb begin
        last  = (remaining == LW'(1));
        empty = (remaining == '0);
    end

endmodule

`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
// ============================================================================
//  Module   : mac_seq_ctrl
//  Purpose  : Sequencer for the float32 MAC datapath. Clears the MAC,
//             streams operand pairs from dual-port SRAM, drains the MAC
//             pipeline and latches the dot product and overflow flag.
//  Config   : MAC_SEQ_RELU_EN - when defined, negative results are
//             replaced by +0.0 at the sampling point (ovf unaffected).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int AW        = 12,
    parameter int LW        = 12,
    parameter int RD_LAT    = DEF_RD_LAT,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [31:0]   result,
    output logic          ovf,
    output logic          a_rd_en,
    output logic [AW-1:0] a_addr,
    input  logic [31:0]   a_rd_data,
    output logic          b_rd_en,
    output logic [AW-1:0] b_addr,
    input  logic [31:0]   b_rd_data,
    output logic [31:0]   mac_a,
    output logic [31:0]   mac_b,
    output logic          mac_a_valid,
    output logic          mac_b_valid,
    output logic          mac_clear,
    input  logic [31:0]   mac_result,
    input  logic          mac_ovf
);

    localparam int             DRAIN_TOT  = RD_LAT + DRAIN_CYC;
    localparam int             CW         = drain_cnt_w(DRAIN_TOT);
    localparam logic [CW-1:0]  DRAIN_LAST = CW'(DRAIN_TOT - 1);

    state_t        state;
    state_t        state_nxt;
    logic          load;
    logic          advance;
    logic          rd_issue;
    logic          clear_pulse;
    logic          sample;
    logic          last;
    logic          empty;
    logic          vld_tap;
    logic          ovf_acc;
    logic [CW-1:0] drain_cnt;
    logic [31:0]   result_nxt;

    mac_seq_addr_gen #(
        .AW (AW),
        .LW (LW)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .base_a  (base_a),
        .base_b  (base_b),
        .len     (len),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .last    (last),
        .empty   (empty)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state strobes; abort overrides everything outside IDLE
    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        advance     = 1'b0;
        rd_issue    = 1'b0;
        clear_pulse = 1'b0;
        sample      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load      = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                clear_pulse = 1'b1;
                state_nxt   = CLRW;
            end
            CLRW: begin
                state_nxt = empty ? DRAIN : FEED;
            end
            FEED: begin
                rd_issue = 1'b1;
                advance  = 1'b1;
                if (last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    sample    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort && (state != IDLE)) begin
            state_nxt   = IDLE;
            rd_issue    = 1'b0;
            advance     = 1'b0;
            clear_pulse = 1'b0;
            sample      = 1'b0;
        end
    end

    // Strobes and status straight from the FSM decode
    always_comb begin
        a_rd_en   = rd_issue;
        b_rd_en   = rd_issue;
        mac_clear = clear_pulse;
        busy      = (state != IDLE);
        done      = (state == DONE);
        mac_a     = a_rd_data;
        mac_b     = b_rd_data;
    end

    // Read-strobe delay line aligning MAC valid with SRAM data
    generate
        if (RD_LAT == 0) begin : g_no_lat
            assign vld_tap = rd_issue;
        end else begin : g_lat
            logic [RD_LAT-1:0] vld_pipe;
            // Shift the read strobe; abort flushes in-flight beats
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_pipe <= '0;
                end else if (abort) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[0] <= rd_issue;
                    for (int k = 1; k < RD_LAT; k++) begin
                        vld_pipe[k] <= vld_pipe[k-1];
                    end
                end
            end
            assign vld_tap = vld_pipe[RD_LAT-1];
        end
    endgenerate

    // Valid only while the job is live; an abort kills it in the same cycle
    always_comb begin
        mac_a_valid = vld_tap && !abort && ((state == FEED) || (state == DRAIN));
        mac_b_valid = mac_a_valid;
    end

    // Drain counter: runs only while in DRAIN, parked at zero elsewhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if ((state == DRAIN) && !abort) begin
            drain_cnt <= drain_cnt + 1'b1;
        end else begin
            drain_cnt <= '0;
        end
    end

    // Job-local overflow accumulator, restarted when the MAC is cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_acc <= 1'b0;
        end else if (state == CLEAR) begin
            ovf_acc <= 1'b0;
        end else if ((state == FEED) || (state == DRAIN)) begin
            ovf_acc <= ovf_acc | mac_ovf;
        end
    end

    // Optional ReLU applied to the sampled accumulator value
    always_comb begin
`ifdef MAC_SEQ_RELU_EN
        result_nxt = mac_result[31] ? FP32_ZERO : mac_result;
`else
        result_nxt = mac_result;
`endif
    end

    // Result/overflow registers, updated only at a completed drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= FP32_ZERO;
            ovf    <= 1'b0;
        end else if (sample) begin
            result <= result_nxt;
            ovf    <= ovf_acc | mac_ovf;
        end
    end

endmodule

`default_nettype wire
